// File: rtl/primitive_hit_scheduler_pkg.sv
// Shared types for the RayCore primitive hit scheduler.
// Index width, batch size and fixed-point format live here.
package primitive_hit_scheduler_pkg;

    localparam int BVH_PRIMITIVE_INDEX_WIDTH = 16;
    localparam int AABB_TEST_UNIT_SIZE = 4;
    localparam int FIXED_WIDTH = 32;
    localparam int FIXED_FRAC = 16;

    typedef logic [BVH_PRIMITIVE_INDEX_WIDTH-1:0] PrimitiveIndex;
    typedef logic signed [FIXED_WIDTH-1:0] Fixed;

    localparam Fixed FIXED_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_TRAV,
        ISSUE,
        DRAIN,
        DONE
    } PrimitiveHitSchedulerState;

    typedef struct packed {
        logic          Valid;
        PrimitiveIndex Index;
        Fixed          T;
    } ClosestHitData;

endpackage

// File: rtl/primitive_hit_scheduler_closest_lane_select.sv
// Combinational LANES-way argmin over qualifying lanes.
// Lowest lane wins on equal t; nothing beats best_t unless strictly smaller.
module closest_lane_select
    import primitive_hit_scheduler_pkg::*;
#(
    parameter int LANES = AABB_TEST_UNIT_SIZE,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] lane_hit,
    input  Fixed [LANES-1:0] lane_t,
    input  Fixed             t_min,
    input  Fixed             best_t,
    output logic [LW-1:0]    lane,
    output Fixed             t,
    output logic             any
);

    // Running minimum seeded with best_t folds the "< best" test in.
    always_comb begin
        lane = '0;
        t    = best_t;
        any  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_hit[i] &&
                ($signed(lane_t[i]) > $signed(t_min)) &&
                ($signed(lane_t[i]) < $signed(t))) begin
                lane = LW'(i);
                t    = lane_t[i];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/primitive_hit_scheduler.sv
// Drains the primitive group FIFO into the ray/primitive test unit and
// reduces hits to the closest one. Optional: ANY_HIT_EARLY_EXIT_EN.
module primitive_hit_scheduler
    import primitive_hit_scheduler_pkg::*;
#(
    parameter int LANES        = AABB_TEST_UNIT_SIZE,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ray_start,
    input  logic                traversal_done,
    output logic                fifo_reset,
    output logic                fifo_pop,
    input  PrimitiveIndex       fifo_start,
    input  PrimitiveIndex       fifo_end,
    input  logic                fifo_empty,
    output logic                test_req,
    output PrimitiveIndex       test_base,
    input  logic                test_ready,
    input  logic                resp_valid,
    input  PrimitiveIndex       resp_base,
    input  logic [LANES-1:0]    resp_hit,
    input  Fixed [LANES-1:0]    resp_t,
    input  Fixed                t_min,
`ifdef ANY_HIT_EARLY_EXIT_EN
    input  logic                any_hit,
`endif
    output logic                busy,
    output logic                done,
    output logic                hit_valid,
    output PrimitiveIndex       hit_index,
    output Fixed                hit_t,
    output logic                resp_err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    PrimitiveHitSchedulerState state, state_nxt;
    logic [IW-1:0] inflight;
    ClosestHitData best;

    logic          accept;
    logic          absorb;
    logic          replace;
    logic          early_exit;
    logic [LW-1:0] sel_lane;
    Fixed          sel_t;
    logic          sel_any;

    // Responses with nothing outstanding are stale and never reduced.
    assign absorb  = resp_valid && (inflight != '0);
    assign replace = absorb && sel_any;

    closest_lane_select #(
        .LANES(LANES)
    ) u_sel (
        .lane_hit(resp_hit),
        .lane_t  (resp_t),
        .t_min   (t_min),
        .best_t  (best.T),
        .lane    (sel_lane),
        .t       (sel_t),
        .any     (sel_any)
    );

`ifdef ANY_HIT_EARLY_EXIT_EN
    logic any_hit_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            any_hit_q <= 1'b0;
        end else if (state == CLEAR) begin
            any_hit_q <= any_hit;
        end
    end

    assign early_exit = any_hit_q && replace;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        test_req  = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ray_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = WAIT_TRAV;
            end
            WAIT_TRAV: begin
                if (traversal_done) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (early_exit) begin
                    state_nxt = DRAIN;
                end else if (fifo_start < fifo_end) begin
                    if (inflight < IW'(MAX_INFLIGHT)) begin
                        test_req = 1'b1;
                        accept   = test_ready;
                        fifo_pop = test_ready;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && !resp_valid) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = ray_start ? CLEAR : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            inflight <= '0;
            best     <= '{Valid: 1'b0, Index: '0, T: FIXED_MAX};
            resp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                inflight <= '0;
                best     <= '{Valid: 1'b0, Index: '0, T: FIXED_MAX};
                resp_err <= 1'b0;
            end else begin
                if (accept && !absorb) begin
                    inflight <= inflight + 1'b1;
                end else if (!accept && absorb) begin
                    inflight <= inflight - 1'b1;
                end
                if (resp_valid && inflight == '0) resp_err <= 1'b1;
                if (replace) begin
                    best <= '{Valid: 1'b1,
                              Index: resp_base + PrimitiveIndex'(sel_lane),
                              T: sel_t};
                end
            end
        end
    end

    assign fifo_reset = (state == CLEAR);
    assign busy       = state inside {CLEAR, WAIT_TRAV, ISSUE, DRAIN};
    assign done       = (state == DONE);
    assign test_base  = test_req ? fifo_start : '0;
    assign hit_valid  = best.Valid;
    assign hit_index  = best.Index;
    // best.T idles at FIXED_MAX, but the visible distance reads 0 without a hit.
    assign hit_t      = best.Valid ? best.T : '0;

endmodule

// File: tb/tb_primitive_hit_scheduler.sv
// Randomized bench for primitive_hit_scheduler with FIFO/test-unit models
// and a closest-hit reference computed over whole groups.
module tb_primitive_hit_scheduler;
    import primitive_hit_scheduler_pkg::*;

    localparam int LN   = 4;
    localparam int MAXI = 4;

    logic clk = 1'b0;
    logic resetn, ray_start, traversal_done;
    logic fifo_reset, fifo_pop, fifo_empty;
    PrimitiveIndex fifo_start, fifo_end, test_base, resp_base, hit_index;
    logic test_req, test_ready, resp_valid;
    logic [LN-1:0] resp_hit;
    Fixed [LN-1:0] resp_t;
    Fixed t_min, hit_t;
    logic busy, done, hit_valid, resp_err;
`ifdef ANY_HIT_EARLY_EXIT_EN
    logic any_hit;
`endif

    always #5 clk = ~clk;

    primitive_hit_scheduler #(.LANES(LN), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .resetn(resetn), .ray_start(ray_start),
        .traversal_done(traversal_done), .fifo_reset(fifo_reset),
        .fifo_pop(fifo_pop), .fifo_start(fifo_start), .fifo_end(fifo_end),
        .fifo_empty(fifo_empty), .test_req(test_req), .test_base(test_base),
        .test_ready(test_ready), .resp_valid(resp_valid),
        .resp_base(resp_base), .resp_hit(resp_hit), .resp_t(resp_t),
        .t_min(t_min),
`ifdef ANY_HIT_EARLY_EXIT_EN
        .any_hit(any_hit),
`endif
        .busy(busy), .done(done), .hit_valid(hit_valid),
        .hit_index(hit_index), .hit_t(hit_t), .resp_err(resp_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int g_s[$], g_e[$];
    int q_s[$], q_e[$];
    int cur_s = 0, cur_e = 0;
    int exp_b[$], exp_e[$];
    int p_b[$], p_e[$], p_due[$];
    bit hit_tab[512];
    int t_tab[512];

    int ready_hold, ready_pct, resp_pct, lat_min, lat_max, trav_delay;
    int max_out, pops_after, exit_cyc;
    bit early, exit_seen, stray;

    bit s_done, s_busy, s_hv, s_err;
    int s_hi, s_ht;
    bit d_hv;
    int d_hi, d_ht;
    bit m_v;
    int m_idx, m_t;

    task automatic check(string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, $signed(act), $signed(req));
        end
    endtask

    task automatic drive();
        fifo_start = PrimitiveIndex'(cur_s);
        fifo_end   = PrimitiveIndex'(cur_e);
        fifo_empty = (q_s.size() == 0) && (cur_s >= cur_e);
        test_ready = (ready_hold == 0) &&
                     ($urandom_range(99) < ready_pct);
        resp_valid = 1'b0;
        resp_base  = '0;
        resp_hit   = '0;
        resp_t     = '0;
        if (stray) begin
            resp_valid = 1'b1;
            resp_base  = 16'd5;
            resp_hit   = '1;
            for (int i = 0; i < LN; i++) resp_t[i] = 32'sh0001_0000;
        end else if (p_b.size() > 0 && p_due[0] <= cyc + 1 &&
                     $urandom_range(99) < resp_pct) begin
            resp_valid = 1'b1;
            resp_base  = PrimitiveIndex'(p_b[0]);
            for (int i = 0; i < LN; i++) begin
                int p;
                p = p_b[0] + i;
                resp_hit[i] = (p < p_e[0]) && hit_tab[p];
                resp_t[i]   = Fixed'(t_tab[p]);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        s_done = done;
        s_busy = busy;
        s_hv   = hit_valid;
        s_hi   = int'(hit_index);
        s_ht   = int'(hit_t);
        s_err  = resp_err;
        if (resp_valid && p_b.size() > 0) begin
            if (early && !exit_seen && (|resp_hit)) begin
                exit_seen = 1'b1;
                exit_cyc  = cyc;
            end
            void'(p_b.pop_front());
            void'(p_e.pop_front());
            void'(p_due.pop_front());
        end
        if (early && exit_seen && cyc > exit_cyc && fifo_pop) pops_after++;
        if (!traversal_done) begin
            check("pop_before_trav", fifo_pop, 0);
            check("req_before_trav", test_req, 0);
        end
        if (test_req && test_ready) begin
            check("req_list_left", exp_b.size() != 0, 1);
            check("pop_on_accept", fifo_pop, 1);
            if (exp_b.size() != 0) begin
                check("req_base", test_base, exp_b[0]);
                p_b.push_back(exp_b.pop_front());
                p_e.push_back(exp_e.pop_front());
                p_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            end
        end
        if (fifo_reset) begin
            q_s = g_s;
            q_e = g_e;
            cur_s = 0;
            cur_e = 0;
        end else if (fifo_pop) begin
            if (cur_s < cur_e) begin
                cur_s += LN;
            end else if (q_s.size() > 0) begin
                cur_s = q_s.pop_front();
                cur_e = q_e.pop_front();
            end
        end
        if (p_b.size() > max_out) max_out = p_b.size();
        check("outstanding_le_max", p_b.size() <= MAXI, 1);
        if (traversal_done && ready_hold > 0) ready_hold--;
        @(posedge clk);
        #1;
        drive();
    endtask

    // Closest qualifying t first, then earliest primitive in issue order.
    task automatic model(input int tmin);
        int best;
        best = 32'h7fff_ffff;
        m_v = 1'b0;
        m_idx = 0;
        m_t = 0;
        foreach (g_s[k])
            for (int p = g_s[k]; p < g_e[k]; p++)
                if (hit_tab[p] && t_tab[p] > tmin && t_tab[p] < best)
                    best = t_tab[p];
        foreach (g_s[k])
            for (int p = g_s[k]; p < g_e[k]; p++)
                if (!m_v && hit_tab[p] && t_tab[p] > tmin &&
                    t_tab[p] == best) begin
                    m_v = 1'b1;
                    m_idx = p;
                    m_t = best;
                end
    endtask

    task automatic build_exp();
        exp_b.delete();
        exp_e.delete();
        foreach (g_s[k])
            for (int b = g_s[k]; b < g_e[k]; b += LN) begin
                exp_b.push_back(b);
                exp_e.push_back(g_e[k]);
            end
    endtask

    task automatic clear_tab();
        for (int p = 0; p < 512; p++) begin
            hit_tab[p] = 1'b0;
            t_tab[p] = int'($urandom_range(40)) * 8192;
        end
    endtask

    task automatic set_env(int hold, int rp, int sp, int lmin, int lmax);
        ready_hold = hold;
        ready_pct = rp;
        resp_pct = sp;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ray_start = 1'b0;
        traversal_done = 1'b0;
        p_b.delete();
        p_e.delete();
        p_due.delete();
        exp_b.delete();
        exp_e.delete();
        resp_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic run_ray(string name, int tmin, bit early_en);
        int n;
        build_exp();
        model(tmin);
        t_min = Fixed'(tmin);
        early = early_en;
        exit_seen = 1'b0;
        pops_after = 0;
        max_out = 0;
`ifdef ANY_HIT_EARLY_EXIT_EN
        any_hit = early_en;
`endif
        ray_start = 1'b1;
        step();
        ray_start = 1'b0;
        repeat (trav_delay) step();
        traversal_done = 1'b1;
        n = 0;
        s_done = 1'b0;
        while (!s_done && n < 3000) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, s_done, 1);
        d_hv = s_hv;
        d_hi = s_hi;
        d_ht = s_ht;
        if (s_done) begin
            if (!early_en) begin
                check({name, "_hit_valid"}, s_hv, m_v);
                check({name, "_hit_index"}, s_hi, m_idx);
                check({name, "_hit_t"}, s_ht, m_t);
                check({name, "_all_issued"}, exp_b.size(), 0);
            end
            check({name, "_none_pending"}, p_b.size(), 0);
            check({name, "_no_err"}, s_err, 0);
        end
        traversal_done = 1'b0;
        step();
        check({name, "_done_pulse"}, s_done, 0);
        check({name, "_hold_index"}, s_hi, d_hi);
        if (!s_done && n >= 3000) do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        resetn = 1'b0;
        ray_start = 1'b0;
        traversal_done = 1'b0;
        t_min = '0;
        stray = 1'b0;
        early = 1'b0;
        trav_delay = 2;
`ifdef ANY_HIT_EARLY_EXIT_EN
        any_hit = 1'b0;
`endif
        set_env(0, 100, 100, 1, 1);
        clear_tab();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {busy, done, test_req, fifo_pop,
                            fifo_reset, hit_valid, resp_err}, 0);
        check("rst_hit_index", hit_index, 0);
        check("rst_hit_t", hit_t, 0);
        check("rst_test_base", test_base, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive();
        step();

        // Globals only: one batch at 125, lane 1 hits at 2.0.
        g_s = '{125};
        g_e = '{128};
        clear_tab();
        hit_tab[126] = 1'b1;
        t_tab[126] = 32'h0002_0000;
        hit_tab[128] = 1'b1;
        t_tab[128] = 32'h0000_1000;
        run_ray("t1", 0, 1'b0);
        check("t1_index_lit", d_hi, 126);
        check("t1_t_lit", d_ht, 32'h0002_0000);

        g_s = '{40, 0};
        g_e = '{46, 4};
        clear_tab();
        hit_tab[41] = 1'b1;
        t_tab[41] = 5 << 16;
        hit_tab[2] = 1'b1;
        t_tab[2] = 3 << 16;
        set_env(0, 70, 80, 1, 4);
        run_ray("t2", 0, 1'b0);
        check("t2_index_lit", d_hi, 2);

        g_s = '{8};
        g_e = '{16};
        clear_tab();
        foreach (hit_tab[p]) t_tab[p] = 4 << 16;
        hit_tab[9] = 1'b1;
        t_tab[9] = 32'h0001_8000;
        hit_tab[10] = 1'b1;
        t_tab[10] = 32'h0001_8000;
        hit_tab[13] = 1'b1;
        t_tab[13] = 32'h0001_8000;
        set_env(0, 100, 100, 2, 2);
        run_ray("t3", 0, 1'b0);
        check("t3_index_lit", d_hi, 9);

        stray = 1'b1;
        step();
        stray = 1'b0;
        step();
        step();
        check("stray_err", s_err, 1);
        check("stray_keeps_index", s_hi, 9);

        g_s = '{0};
        g_e = '{40};
        clear_tab();
        hit_tab[37] = 1'b1;
        t_tab[37] = 1 << 16;
        set_env(10, 100, 100, 20, 20);
        run_ray("t4", 0, 1'b0);
        check("t4_peak_inflight", max_out, MAXI);

        set_env(0, 100, 100, 20, 20);
        build_exp();
        t_min = '0;
        ray_start = 1'b1;
        step();
        ray_start = 1'b0;
        traversal_done = 1'b1;
        n = 0;
        while (p_b.size() < 3 && n < 200) begin
            step();
            n++;
        end
        check("t5_three_inflight", p_b.size(), 3);
        resetn = 1'b0;
        #2;
        check("t5_rst_flags", {busy, done, test_req, fifo_pop,
                               fifo_reset, hit_valid}, 0);
        check("t5_rst_index", hit_index, 0);
        check("t5_rst_t", hit_t, 0);
        do_reset();
        g_s = '{20, 60};
        g_e = '{27, 65};
        clear_tab();
        hit_tab[25] = 1'b1;
        t_tab[25] = -(1 << 16);
        hit_tab[62] = 1'b1;
        t_tab[62] = 6 << 16;
        hit_tab[21] = 1'b1;
        t_tab[21] = 6 << 16;
        set_env(0, 80, 80, 1, 5);
        run_ray("t5_next", 0, 1'b0);
        check("t5_index_lit", d_hi, 21);

        g_s.delete();
        g_e.delete();
        run_ray("empty", 0, 1'b0);
        check("empty_no_hit", d_hv, 0);

        for (int r = 0; r < 25; r++) begin
            int b, ng, sz;
            g_s.delete();
            g_e.delete();
            ng = $urandom_range(4, 1);
            b = $urandom_range(20);
            for (int k = 0; k < ng; k++) begin
                sz = $urandom_range(12, 1);
                g_s.push_back(b);
                g_e.push_back(b + sz);
                b = b + sz + int'($urandom_range(16));
            end
            clear_tab();
            for (int p = 0; p < 512; p++) begin
                hit_tab[p] = ($urandom_range(99) < 40);
                t_tab[p] = (int'($urandom_range(24)) - 4) * 16384;
            end
            trav_delay = $urandom_range(3);
            set_env($urandom_range(3), $urandom_range(100, 40),
                    $urandom_range(100, 50), 1, $urandom_range(8, 1));
            run_ray("rand", (int'($urandom_range(4)) - 1) * 16384, 1'b0);
        end

`ifdef ANY_HIT_EARLY_EXIT_EN
        g_s = '{0};
        g_e = '{40};
        clear_tab();
        hit_tab[1] = 1'b1;
        t_tab[1] = 1 << 16;
        trav_delay = 2;
        set_env(0, 100, 100, 3, 3);
        run_ray("early", 0, 1'b1);
        check("early_hit_valid", d_hv, 1);
        check("early_index", d_hi, 1);
        check("early_no_pop_after", pops_after, 0);
        check("early_hit_seen", exit_seen, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
